// File: rtl/fib_pkg.sv
// Shared definitions for the generalised-Fibonacci engine and the legacy fib users.
package fib_pkg;

  localparam int unsigned FIB_WIDTH = 32;
  localparam int unsigned FIB_IDX_W = 6;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } fib_state_t;

endpackage

// File: rtl/fib_seq_gen_if.sv
// Request/result handshake bundle between producer, fib_seq_gen and consumer.
interface fib_seq_gen_if
  import fib_pkg::*;
#(
  parameter int unsigned WIDTH = FIB_WIDTH,
  parameter int unsigned IDX_W = FIB_IDX_W
);

  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] n;
  logic [WIDTH-1:0] seed0;
  logic [WIDTH-1:0] seed1;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_next;
  logic             overflow;
  logic             busy;

  modport master (
    output in_valid, n, seed0, seed1, out_ready,
    input  in_ready, out_valid, result, result_next, overflow, busy
  );

  modport slave (
    input  in_valid, n, seed0, seed1, out_ready,
    output in_ready, out_valid, result, result_next, overflow, busy
  );

endinterface

// File: rtl/fib_step_dp.sv
// One Fibonacci step: shifts the pair forward and tracks sticky carries per term.
module fib_step_dp #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             a_ovf_i,
  input  logic             b_ovf_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic             a_ovf_o,
  output logic             b_ovf_o
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum     = {1'b0, a_i} + {1'b0, b_i};
    a_o     = b_i;
    b_o     = sum[WIDTH-1:0];
    a_ovf_o = b_ovf_i;
    // A term is tainted if either operand was, or its own sum carried out.
    b_ovf_o = a_ovf_i | b_ovf_i | sum[WIDTH];
  end

endmodule

// File: rtl/fib_seq_gen.sv
// Generalised-Fibonacci engine: returns F(n), F(n+1) and a sticky overflow flag.
module fib_seq_gen
  import fib_pkg::*;
#(
  parameter int unsigned WIDTH = FIB_WIDTH,
  parameter int unsigned IDX_W = FIB_IDX_W
) (
  input  logic        clk,
  input  logic        rst,
  fib_seq_gen_if.slave bus
);

  fib_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             a_ovf_q, a_ovf_d, b_ovf_q, b_ovf_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] step_a, step_b;
  logic             step_a_ovf, step_b_ovf;

  fib_step_dp #(
    .WIDTH (WIDTH)
  ) u_step (
    .a_i     (a_q),
    .b_i     (b_q),
    .a_ovf_i (a_ovf_q),
    .b_ovf_i (b_ovf_q),
    .a_o     (step_a),
    .b_o     (step_b),
    .a_ovf_o (step_a_ovf),
    .b_ovf_o (step_b_ovf)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    a_ovf_d = a_ovf_q;
    b_ovf_d = b_ovf_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = RUN;
          a_d     = bus.seed0;
          b_d     = bus.seed1;
          a_ovf_d = 1'b0;
          b_ovf_d = 1'b0;
          cnt_d   = bus.n;
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          a_d     = step_a;
          b_d     = step_b;
          a_ovf_d = step_a_ovf;
          b_ovf_d = step_b_ovf;
          cnt_d   = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      a_ovf_q <= 1'b0;
      b_ovf_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      a_ovf_q <= a_ovf_d;
      b_ovf_q <= b_ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = (state_q == DONE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.result      = a_q;
  assign bus.result_next = b_q;
  assign bus.overflow    = a_ovf_q;

endmodule

// File: tb/tb_fib_seq_gen.sv
// Scoreboard bench for fib_seq_gen: driver queues expected results, monitor checks on drain.
module tb_fib_seq_gen;

  localparam int unsigned Width = 32;
  localparam int unsigned IdxW  = 6;

  typedef struct {
    logic [Width-1:0] res;
    logic [Width-1:0] res_next;
    logic             ovf;
    int               valid_cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_cmp;
  int   n_bad;
  exp_t exp_q[$];

  fib_seq_gen_if #(.WIDTH(Width), .IDX_W(IdxW)) bus ();

  fib_seq_gen #(
    .WIDTH (Width),
    .IDX_W (IdxW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares whenever the consumer takes a result.
  logic seen_q;
  int   first_cyc;
  initial seen_q = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      seen_q = 1'b0;
    end else if (bus.out_valid) begin
      if (!seen_q) begin
        seen_q    = 1'b1;
        first_cyc = cyc;
      end
      if (bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("result", 64'(bus.result), 64'(e.res));
          chk("result_next", 64'(bus.result_next), 64'(e.res_next));
          chk("overflow", 64'(bus.overflow), 64'(e.ovf));
          chk("latency", 64'(first_cyc), 64'(e.valid_cyc));
        end
        seen_q = 1'b0;
      end
    end
  end

  // Drive a request; the expected response is queued at the accepting edge.
  task automatic send(input logic [IdxW-1:0] n, input logic [Width-1:0] s0,
                      input logic [Width-1:0] s1, input bit expect_out,
                      input logic [Width-1:0] r, input logic [Width-1:0] rn, input logic ovf);
    bit   got;
    exp_t e;
    bus.in_valid = 1'b1;
    bus.n        = n;
    bus.seed0    = s0;
    bus.seed1    = s1;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (bus.in_ready) got = 1'b1;
    end
    if (!got) begin
      chk("accept_timeout", 64'd0, 64'd1);
    end else if (expect_out) begin
      e.res       = r;
      e.res_next  = rn;
      e.ovf       = ovf;
      // Accept edge is cyc+1; out_valid is first visible n+1 edges later.
      e.valid_cyc = cyc + 1 + int'(n) + 1;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < 300) begin
      @(negedge clk);
      i++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_result"}, 64'(bus.result), 64'd0);
    chk({tag, "_result_next"}, 64'(bus.result_next), 64'd0);
    chk({tag, "_overflow"}, 64'(bus.overflow), 64'd0);
  endtask

  initial begin
    bit got;
    bit leaked;
    n_cmp         = 0;
    n_bad         = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.n         = '0;
    bus.seed0     = '0;
    bus.seed1     = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_idle_zero("reset");
    @(posedge clk);
    #1;

    send(6'd10, 32'd0, 32'd1, 1'b1, 32'd55, 32'd89, 1'b0);
    drain();
    send(6'd0, 32'd0, 32'd1, 1'b1, 32'd0, 32'd1, 1'b0);
    drain();
    send(6'd5, 32'd2, 32'd1, 1'b1, 32'd11, 32'd18, 1'b0);
    drain();
    send(6'd47, 32'd0, 32'd1, 1'b1, 32'd2971215073, 32'd512559680, 1'b0);
    drain();
    send(6'd48, 32'd0, 32'd1, 1'b1, 32'd512559680, 32'd3483774753, 1'b1);
    drain();
    // Carry into F(n+1) alone must not raise overflow; one step later it must.
    send(6'd1, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'd1, 32'd0, 1'b0);
    drain();
    send(6'd2, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'd0, 32'd1, 1'b1);
    drain();
    send(6'd63, 32'd0, 32'd0, 1'b1, 32'd0, 32'd0, 1'b0);
    drain();

    // Backpressure with a competing request held on the input side.
    bus.out_ready = 1'b0;
    send(6'd7, 32'd0, 32'd1, 1'b1, 32'd13, 32'd21, 1'b0);
    bus.in_valid = 1'b1;
    bus.n        = 6'd3;
    bus.seed0    = 32'd5;
    bus.seed1    = 32'd5;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (bus.out_valid) got = 1'b1;
    end
    if (!got) chk("bp_valid_timeout", 64'd0, 64'd1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_result", 64'(bus.result), 64'd13);
      chk("bp_result_next", 64'(bus.result_next), 64'd21);
      chk("bp_overflow", 64'(bus.overflow), 64'd0);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_busy", 64'(bus.busy), 64'd1);
      @(negedge clk);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(negedge clk);
    chk("no_overlap_in_ready", 64'(bus.in_ready), 64'd0);
    // 5,5,10,15,25: F(3)=15, F(4)=25.
    send(6'd3, 32'd5, 32'd5, 1'b1, 32'd15, 32'd25, 1'b0);
    drain();

    // Reset in the 4th RUN cycle aborts the request.
    send(6'd20, 32'd0, 32'd1, 1'b0, 32'd0, 32'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_idle_zero("abort");
    leaked = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.out_valid) leaked = 1'b1;
    end
    chk("abort_no_out_valid", 64'(leaked), 64'd0);
    @(posedge clk);
    #1;
    send(6'd3, 32'd0, 32'd1, 1'b1, 32'd2, 32'd3, 1'b0);
    drain();

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
